noc_ring_stop: RTL and testbench

Ring-network stop that sits opposite a GPU's 16-bit network port. It accepts flits injected by the local GPU and forwards transit ring traffic. It ejects flits addressed to this node into the GPU's receive port. Flit format is {dest[15:10], payload[9:0]}, and one stop instantiates per GPU on the NoC ring.

---
 rtl/noc_ring_stop.sv | 152 +++++++++++++++
 tb/tb_noc_ring_stop.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ring_stop.sv
// Ring stop: merges local injection and upstream ring traffic onto one output
// register and an ejection FIFO, with starvation relief for the injection head.
module noc_ring_stop #(
    parameter int NODE_ID      = 22,
    parameter int NUM_NODES    = 32,
    parameter int INJ_DEPTH    = 4,
    parameter int EJ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [15:0] inj_data,
    input  logic        inj_valid,
    output logic        inj_ready,
    output logic [15:0] ej_data,
    output logic        ej_valid,
    input  logic        ej_ready,
    input  logic [15:0] ring_in_data,
    input  logic        ring_in_valid,
    output logic        ring_in_ready,
    output logic [15:0] ring_out_data,
    output logic        ring_out_valid,
    input  logic        ring_out_ready,
    output logic [7:0]  drop_count
);
    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);
    localparam int SW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [5:0]    NODE_ID_L      = 6'(NODE_ID);
    localparam logic [6:0]    NUM_NODES_L    = 7'(NUM_NODES);
    localparam logic [SW-1:0] STARVE_LIMIT_L = SW'(STARVE_LIMIT);

    logic [15:0]   inj_mem [INJ_DEPTH];
    logic [IAW:0]  inj_wr_ptr;
    logic [IAW:0]  inj_rd_ptr;
    logic [15:0]   ej_mem [EJ_DEPTH];
    logic [EAW:0]  ej_wr_ptr;
    logic [EAW:0]  ej_rd_ptr;
    logic [SW-1:0] starve_cnt;

    logic          inj_full;
    logic          inj_empty;
    logic          ej_full;
    logic          ej_empty;
    logic [15:0]   inj_head;
    logic          out_free;
    logic          starve_grant;
    logic          ring_xfer;
    logic          ring_local;
    logic          inj_local;
    logic          inj_target_free;
    logic          ring_claims_inj;
    logic          inj_pop;
    logic          inj_accept;
    logic          inj_unroutable;
    logic          inj_write;
    logic          ej_write;
    logic [15:0]   ej_wdata;
    logic          ej_read;
    logic          out_load;
    logic [15:0]   out_wdata;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign inj_empty = (inj_wr_ptr == inj_rd_ptr);
    assign inj_full  = (inj_wr_ptr[IAW] != inj_rd_ptr[IAW]) &&
                       (inj_wr_ptr[IAW-1:0] == inj_rd_ptr[IAW-1:0]);
    assign ej_empty  = (ej_wr_ptr == ej_rd_ptr);
    assign ej_full   = (ej_wr_ptr[EAW] != ej_rd_ptr[EAW]) &&
                       (ej_wr_ptr[EAW-1:0] == ej_rd_ptr[EAW-1:0]);

    assign inj_head = inj_mem[inj_rd_ptr[IAW-1:0]];
    assign ej_data  = ej_mem[ej_rd_ptr[EAW-1:0]];
    assign ej_valid = !ej_empty;
    assign ej_read  = ej_valid && ej_ready;

    assign out_free      = !ring_out_valid || ring_out_ready;
    assign starve_grant  = (starve_cnt == STARVE_LIMIT_L);
    assign ring_in_ready = ARESETn && out_free && !ej_full && !starve_grant;
    assign ring_xfer     = ring_in_valid && ring_in_ready;
    assign ring_local    = (ring_in_data[15:10] == NODE_ID_L);

    // Ring traffic wins its target; the injection head only takes the other one.
    assign inj_local       = (inj_head[15:10] == NODE_ID_L);
    assign inj_target_free = inj_local ? !ej_full : out_free;
    assign ring_claims_inj = ring_xfer && (ring_local == inj_local);
    assign inj_pop         = !inj_empty && inj_target_free && !ring_claims_inj;

    assign inj_ready      = ARESETn && !inj_full;
    assign inj_accept     = inj_valid && inj_ready;
    assign inj_unroutable = ({1'b0, inj_data[15:10]} >= NUM_NODES_L);
    assign inj_write      = inj_accept && !inj_unroutable;

    assign ej_write  = (ring_xfer && ring_local) || (inj_pop && inj_local);
    assign ej_wdata  = (ring_xfer && ring_local) ? ring_in_data : inj_head;
    assign out_load  = (ring_xfer && !ring_local) || (inj_pop && !inj_local);
    assign out_wdata = (ring_xfer && !ring_local) ? ring_in_data : inj_head;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            inj_wr_ptr     <= '0;
            inj_rd_ptr     <= '0;
            ej_wr_ptr      <= '0;
            ej_rd_ptr      <= '0;
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
            drop_count     <= '0;
            starve_cnt     <= '0;
        end else begin
            if (inj_write) begin
                inj_wr_ptr <= inj_wr_ptr + 1'b1;
            end
            if (inj_pop) begin
                inj_rd_ptr <= inj_rd_ptr + 1'b1;
            end
            if (ej_write) begin
                ej_wr_ptr <= ej_wr_ptr + 1'b1;
            end
            if (ej_read) begin
                ej_rd_ptr <= ej_rd_ptr + 1'b1;
            end

            if (out_load) begin
                ring_out_valid <= 1'b1;
                ring_out_data  <= out_wdata;
            end else if (ring_out_ready) begin
                ring_out_valid <= 1'b0;
            end

            if (inj_accept && inj_unroutable && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end

            // Only losing to a ring claim counts as starvation, not a busy target.
            if (inj_empty || inj_pop || starve_grant) begin
                starve_cnt <= '0;
            end else if (inj_target_free && ring_claims_inj) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (inj_write) begin
            inj_mem[inj_wr_ptr[IAW-1:0]] <= inj_data;
        end
        if (ej_write) begin
            ej_mem[ej_wr_ptr[EAW-1:0]] <= ej_wdata;
        end
    end

endmodule

// File: tb/tb_noc_ring_stop.sv
// Bench for noc_ring_stop: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_noc_ring_stop;
    localparam int NODE_ID      = 22;
    localparam int NUM_NODES    = 32;
    localparam int INJ_DEPTH    = 4;
    localparam int EJ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 8;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [15:0] inj_data = '0;
    logic        inj_valid = 1'b0;
    logic        inj_ready;
    logic [15:0] ej_data;
    logic        ej_valid;
    logic        ej_ready = 1'b1;
    logic [15:0] ring_in_data = '0;
    logic        ring_in_valid = 1'b0;
    logic        ring_in_ready;
    logic [15:0] ring_out_data;
    logic        ring_out_valid;
    logic        ring_out_ready = 1'b1;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    noc_ring_stop #(
        .NODE_ID(NODE_ID), .NUM_NODES(NUM_NODES), .INJ_DEPTH(INJ_DEPTH),
        .EJ_DEPTH(EJ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
        .ej_data(ej_data), .ej_valid(ej_valid), .ej_ready(ej_ready),
        .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid),
        .ring_in_ready(ring_in_ready),
        .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid),
        .ring_out_ready(ring_out_ready), .drop_count(drop_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Reference model: two flit queues, the output stage and two counters.
    logic [15:0] inj_q[$];
    logic [15:0] ej_q[$];
    logic        m_out_v = 1'b0;
    logic [15:0] m_out_d = '0;
    int          m_drop = 0;
    int          m_starve = 0;

    function automatic logic to_me(input logic [15:0] f);
        return int'(f[15:10]) == NODE_ID;
    endfunction

    function automatic logic m_ring_rdy();
        return ARESETn && (!m_out_v || ring_out_ready) &&
               (ej_q.size() < EJ_DEPTH) && (m_starve != STARVE_LIMIT);
    endfunction

    always @(posedge ACLK or negedge ARESETn) begin
        logic        rx, ip, blocked, hl, free_t, ej_rd, acc, was_empty, grant;
        logic [15:0] h;
        if (!ARESETn) begin
            inj_q.delete();
            ej_q.delete();
            m_out_v  = 1'b0;
            m_out_d  = '0;
            m_drop   = 0;
            m_starve = 0;
        end else begin
            grant     = (m_starve == STARVE_LIMIT);
            rx        = ring_in_valid && m_ring_rdy();
            ip        = 1'b0;
            blocked   = 1'b0;
            hl        = 1'b0;
            h         = '0;
            was_empty = (inj_q.size() == 0);
            if (!was_empty) begin
                h       = inj_q[0];
                hl      = to_me(h);
                free_t  = hl ? (ej_q.size() < EJ_DEPTH) : (!m_out_v || ring_out_ready);
                ip      = free_t && !(rx && (to_me(ring_in_data) == hl));
                blocked = free_t && rx && (to_me(ring_in_data) == hl);
            end
            ej_rd = (ej_q.size() > 0) && ej_ready;
            acc   = inj_valid && (inj_q.size() < INJ_DEPTH);

            if (ej_rd) void'(ej_q.pop_front());
            if (rx && to_me(ring_in_data)) ej_q.push_back(ring_in_data);
            else if (ip && hl) ej_q.push_back(h);

            if (rx && !to_me(ring_in_data)) begin
                m_out_v = 1'b1;
                m_out_d = ring_in_data;
            end else if (ip && !hl) begin
                m_out_v = 1'b1;
                m_out_d = h;
            end else if (ring_out_ready) begin
                m_out_v = 1'b0;
            end

            if (ip) void'(inj_q.pop_front());
            if (acc) begin
                if (int'(inj_data[15:10]) >= NUM_NODES) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    inj_q.push_back(inj_data);
                end
            end

            if (was_empty || ip || grant) m_starve = 0;
            else if (blocked) m_starve++;
        end
    end

    always @(negedge ACLK) begin
        if (cmp_en) begin
            chk("m_ring_out_valid", 32'(ring_out_valid), 32'(m_out_v));
            if (m_out_v) chk("m_ring_out_data", 32'(ring_out_data), 32'(m_out_d));
            chk("m_ej_valid", 32'(ej_valid), 32'(ej_q.size() > 0));
            if (ej_q.size() > 0) chk("m_ej_data", 32'(ej_data), 32'(ej_q[0]));
            chk("m_inj_ready", 32'(inj_ready), 32'(ARESETn && (inj_q.size() < INJ_DEPTH)));
            chk("m_ring_in_ready", 32'(ring_in_ready), 32'(m_ring_rdy()));
            chk("m_drop_count", 32'(drop_count), 32'(m_drop));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen, low_cnt, low_at;
        logic rdy, xfer;
        logic [15:0] got[$];

        // Reset state
        tick();
        chk("rst_ring_out_valid", 32'(ring_out_valid), 32'd0);
        chk("rst_ring_out_data", 32'(ring_out_data), 32'd0);
        chk("rst_ej_valid", 32'(ej_valid), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_inj_ready", 32'(inj_ready), 32'd0);
        chk("rst_ring_in_ready", 32'(ring_in_ready), 32'd0);
        cmp_en = 1'b1;
        tick();
        ARESETn = 1'b1;
        tick();

        // 1: injection to dest 23 appears on ring_out two cycles later
        inj_data = 16'h5C05; inj_valid = 1'b1;
        chk("t1_inj_ready", 32'(inj_ready), 32'd1);
        tick();
        inj_valid = 1'b0;
        chk("t1_out_valid_c1", 32'(ring_out_valid), 32'd0);
        tick();
        chk("t1_out_valid_c2", 32'(ring_out_valid), 32'd1);
        chk("t1_out_data", 32'(ring_out_data), 32'h5C05);
        chk("t1_ej_valid", 32'(ej_valid), 32'd0);
        tick();
        tick();

        // 2: ring flit for us ejects, next ring flit passes through
        ring_in_data = 16'h5815; ring_in_valid = 1'b1;
        chk("t2_ring_in_ready", 32'(ring_in_ready), 32'd1);
        tick();
        ring_in_data = 16'h5C01;
        chk("t2_ej_valid", 32'(ej_valid), 32'd1);
        chk("t2_ej_data", 32'(ej_data), 32'h5815);
        chk("t2_out_valid_c1", 32'(ring_out_valid), 32'd0);
        tick();
        ring_in_valid = 1'b0;
        chk("t2_out_valid_c2", 32'(ring_out_valid), 32'd1);
        chk("t2_out_data", 32'(ring_out_data), 32'h5C01);
        chk("t2_ej_empty", 32'(ej_valid), 32'd0);
        tick();
        tick();

        // 3: unroutable injections are dropped and counted, saturating
        inj_data = 16'hA000; inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        chk("t3_drop_1", 32'(drop_count), 32'd1);
        chk("t3_inj_ready", 32'(inj_ready), 32'd1);
        tick();
        chk("t3_no_out", 32'(ring_out_valid), 32'd0);
        chk("t3_no_ej", 32'(ej_valid), 32'd0);
        inj_valid = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        inj_valid = 1'b0;
        chk("t3_drop_sat", 32'(drop_count), 32'd255);
        chk("t3_inj_ready_end", 32'(inj_ready), 32'd1);
        tick();

        // 4: ejection backpressure and in-order delivery
        ej_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ring_in_data = 16'(16'h5801 + i); ring_in_valid = 1'b1;
            n = 0;
            while (!ring_in_ready && n < 50) begin tick(); n++; end
            chk("t4_accept_ready", 32'(ring_in_ready), 32'd1);
            tick();
        end
        ring_in_data = 16'h5805;
        chk("t4_full_ready", 32'(ring_in_ready), 32'd0);
        tick();
        tick();
        chk("t4_hold_ready", 32'(ring_in_ready), 32'd0);
        ej_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 30 && got.size() < 5; k++) begin
            xfer = ring_in_valid && ring_in_ready;
            if (ej_valid) got.push_back(ej_data);
            tick();
            if (xfer) ring_in_valid = 1'b0;
        end
        chk("t4_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size(); i++) chk("t4_order", 32'(got[i]), 32'(16'h5801 + i));
        chk("t4_ready_back", 32'(ring_in_ready), 32'd1);
        tick();

        // 5: starvation relief under continuous ring traffic
        ring_in_data = 16'h5C20; ring_in_valid = 1'b1;
        inj_data = 16'h6000; inj_valid = 1'b1;
        chk("t5_inj_ready", 32'(inj_ready), 32'd1);
        rdy = ring_in_ready;
        tick();
        if (rdy) ring_in_data = ring_in_data + 16'd1;
        inj_valid = 1'b0;
        seen = -1; low_cnt = 0; low_at = -1;
        for (int k = 1; k <= 14; k++) begin
            if (!ring_in_ready) begin
                low_cnt++;
                if (low_at < 0) low_at = k;
            end
            if (ring_out_valid && ring_out_data == 16'h6000 && seen < 0) seen = k;
            rdy = ring_in_ready;
            tick();
            if (rdy) ring_in_data = ring_in_data + 16'd1;
        end
        ring_in_valid = 1'b0;
        chk("t5_inj_out_cycle", 32'(seen), 32'(STARVE_LIMIT + 2));
        chk("t5_low_cycles", 32'(low_cnt), 32'd1);
        chk("t5_low_at", 32'(low_at), 32'(STARVE_LIMIT + 1));
        tick();
        tick();

        // 6: reset with flits buffered in both FIFOs
        ring_out_ready = 1'b0; ej_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ring_in_data = 16'(16'h5801 + i); ring_in_valid = 1'b1;
            chk("t6_ring_ready", 32'(ring_in_ready), 32'd1);
            tick();
        end
        ring_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inj_data = 16'(16'h5C11 + i); inj_valid = 1'b1;
            chk("t6_inj_ready", 32'(inj_ready), 32'd1);
            tick();
        end
        inj_valid = 1'b0;
        inj_data = 16'hA000; inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        chk("t6_pre_out_data", 32'(ring_out_data), 32'h5C11);
        chk("t6_pre_ej_data", 32'(ej_data), 32'h5801);
        chk("t6_pre_drop", 32'(drop_count), 32'd255);
        ARESETn = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(ring_out_valid), 32'd0);
        chk("t6_rst_ej_valid", 32'(ej_valid), 32'd0);
        chk("t6_rst_drop", 32'(drop_count), 32'd0);
        chk("t6_rst_inj_ready", 32'(inj_ready), 32'd0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        ring_out_ready = 1'b1; ej_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t6_no_stale_out", 32'(ring_out_valid), 32'd0);
            chk("t6_no_stale_ej", 32'(ej_valid), 32'd0);
        end
        chk("t6_drop_after", 32'(drop_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
